// File: rtl/sobel_frame_arbiter.sv
// Shares one sobel_filter between two pixel requesters one whole frame at a time; optional stats via SOBEL_FRAME_ARB_STATS_EN.
// Latency: 1 idle cycle per frame grant, then zero-latency pass-through on both the input and output sides.
// Backpressure: transfers stall on an empty source or full destination; a full tag queue holds off new grants.
module sobel_frame_arbiter #(
  parameter int WIDTH     = 720,
  parameter int HEIGHT    = 540,
  parameter int TAG_DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  output logic       req0_rd_en,
  input  logic       req0_empty,
  input  logic [7:0] req0_dout,
  output logic       req1_rd_en,
  input  logic       req1_empty,
  input  logic [7:0] req1_dout,
  output logic       flt_wr_en,
  input  logic       flt_full,
  output logic [7:0] flt_din,
  output logic       flt_rd_en,
  input  logic       flt_empty,
  input  logic [7:0] flt_dout,
  output logic       out0_wr_en,
  input  logic       out0_full,
  output logic [7:0] out0_din,
  output logic       out1_wr_en,
  input  logic       out1_full,
  output logic [7:0] out1_din,
  output logic       in_busy,
  output logic       in_grant
`ifdef SOBEL_FRAME_ARB_STATS_EN
  ,
  output logic [15:0] frames_done0,
  output logic [15:0] frames_done1,
  output logic [15:0] stall_cycles
`endif
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int PW   = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int QW   = PW + 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);
  localparam logic [QW-1:0] Q_FULL   = QW'(TAG_DEPTH);
  localparam logic [PW-1:0] P_LAST   = PW'(TAG_DEPTH - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state;
  logic [CW-1:0]        in_cnt;
  logic [CW-1:0]        out_cnt;
  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PW-1:0]        tag_wr_ptr;
  logic [PW-1:0]        tag_rd_ptr;
  logic [QW-1:0]        tag_cnt;

  logic       tag_full, tag_empty, tag_head;
  logic       src_empty, dst_full, any_req, next_grant;
  logic [7:0] src_dout;
  logic       in_xfer, out_xfer, tag_push, tag_pop;

  assign tag_full   = (tag_cnt == Q_FULL);
  assign tag_empty  = (tag_cnt == '0);
  assign tag_head   = tag_mem[tag_rd_ptr];

  // The granted requester is the one in_grant names; only meaningful in STREAM.
  assign src_empty  = in_grant ? req1_empty : req0_empty;
  assign src_dout   = in_grant ? req1_dout  : req0_dout;
  assign dst_full   = tag_head ? out1_full  : out0_full;

  // With both requesting, alternate away from the last grant; otherwise take whoever is ready.
  assign any_req    = !req0_empty || !req1_empty;
  assign next_grant = (!req0_empty && !req1_empty) ? ~in_grant : !req1_empty;

  // Reset gates the strobes so no external FIFO is popped or pushed while reset is held.
  assign in_xfer    = !reset && (state == STREAM) && !src_empty && !flt_full;
  assign out_xfer   = !reset && !tag_empty && !flt_empty && !dst_full;
  assign tag_push   = (state == IDLE) && !tag_full && any_req;
  assign tag_pop    = out_xfer && (out_cnt == LAST_PIX);

  assign req0_rd_en = in_xfer && !in_grant;
  assign req1_rd_en = in_xfer &&  in_grant;
  assign flt_wr_en  = in_xfer;
  assign flt_din    = in_xfer ? src_dout : 8'd0;
  assign flt_rd_en  = out_xfer;
  assign out0_wr_en = out_xfer && !tag_head;
  assign out1_wr_en = out_xfer &&  tag_head;
  assign out0_din   = out0_wr_en ? flt_dout : 8'd0;
  assign out1_din   = out1_wr_en ? flt_dout : 8'd0;

  // Input FSM: grant a frame in IDLE, then count WIDTH*HEIGHT pass-through pixels in STREAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      in_busy  <= 1'b0;
      in_grant <= 1'b1;
      in_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tag_push) begin
            in_grant <= next_grant;
            in_busy  <= 1'b1;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (in_xfer) begin
            if (in_cnt == LAST_PIX) begin
              in_cnt  <= '0;
              in_busy <= 1'b0;
              state   <= IDLE;
            end else begin
              in_cnt <= in_cnt + CW'(1);
            end
          end
        end
        default: begin
          in_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Tag queue: frame owners in grant order; push and pop in one cycle leave the count unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_cnt    <= '0;
    end else begin
      if (tag_push) begin
        tag_mem[tag_wr_ptr] <= next_grant;
        tag_wr_ptr          <= (tag_wr_ptr == P_LAST) ? '0 : tag_wr_ptr + PW'(1);
      end
      if (tag_pop) begin
        tag_rd_ptr <= (tag_rd_ptr == P_LAST) ? '0 : tag_rd_ptr + PW'(1);
      end
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + QW'(1);
        2'b01:   tag_cnt <= tag_cnt - QW'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // Output pixel counter: wraps on the last pixel of the frame owned by the head tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_cnt <= '0;
    end else if (out_xfer) begin
      out_cnt <= (out_cnt == LAST_PIX) ? '0 : out_cnt + CW'(1);
    end
  end

`ifdef SOBEL_FRAME_ARB_STATS_EN
  // Per-sink completed frames (wrapping) and saturating count of starved STREAM cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      frames_done0 <= 16'd0;
      frames_done1 <= 16'd0;
      stall_cycles <= 16'd0;
    end else begin
      if (tag_pop && !tag_head) frames_done0 <= frames_done0 + 16'd1;
      if (tag_pop &&  tag_head) frames_done1 <= frames_done1 + 16'd1;
      if (in_busy && src_empty && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_frame_arbiter.sv
// Directed bench for sobel_frame_arbiter with WIDTH=4, HEIGHT=3 (12-pixel frames).
// Requester, filter (loopback) and sink FIFOs are show-ahead queues serviced once per cycle.
module tb_sobel_frame_arbiter;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0_rd_en, req1_rd_en, flt_wr_en, flt_rd_en, out0_wr_en, out1_wr_en;
  logic       req0_empty = 1'b1, req1_empty = 1'b1, flt_full = 1'b0, flt_empty = 1'b1;
  logic       out0_full = 1'b0, out1_full = 1'b0;
  logic [7:0] req0_dout = 8'd0, req1_dout = 8'd0, flt_dout = 8'd0;
  logic [7:0] flt_din, out0_din, out1_din;
  logic       in_busy, in_grant;
`ifdef SOBEL_FRAME_ARB_STATS_EN
  logic [15:0] frames_done0, frames_done1, stall_cycles;
`endif

  sobel_frame_arbiter #(.WIDTH(W), .HEIGHT(H), .TAG_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .req0_rd_en(req0_rd_en), .req0_empty(req0_empty), .req0_dout(req0_dout),
    .req1_rd_en(req1_rd_en), .req1_empty(req1_empty), .req1_dout(req1_dout),
    .flt_wr_en(flt_wr_en), .flt_full(flt_full), .flt_din(flt_din),
    .flt_rd_en(flt_rd_en), .flt_empty(flt_empty), .flt_dout(flt_dout),
    .out0_wr_en(out0_wr_en), .out0_full(out0_full), .out0_din(out0_din),
    .out1_wr_en(out1_wr_en), .out1_full(out1_full), .out1_din(out1_din),
    .in_busy(in_busy), .in_grant(in_grant)
`ifdef SOBEL_FRAME_ARB_STATS_EN
    , .frames_done0(frames_done0), .frames_done1(frames_done1), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Environment state
  logic [7:0] rq0[$], rq1[$], fq[$], s0[$], s1[$];
  logic       grant_log[$];
  int         grant_s0sz[$];
  int         dest_log[$];
  logic       full0_force = 1'b0, full1_force = 1'b0, fullwin_en = 1'b0;
  int cyc, wr_count, wr_first, wr_last, req_first, s_cnt, busy_cycles, rd_in_full, pass_bad;
  logic prev_busy;
  int cur;

  function automatic void clear_stats();
    grant_log.delete(); grant_s0sz.delete(); dest_log.delete();
    cyc = 0; wr_count = 0; wr_first = -1; wr_last = -1; req_first = -1;
    s_cnt = 0; busy_cycles = 0; rd_in_full = 0; pass_bad = 0; prev_busy = 1'b0;
  endfunction

  function automatic void clear_model();
    rq0.delete(); rq1.delete(); fq.delete(); s0.delete(); s1.delete();
    clear_stats();
  endfunction

  // FIFO models: drive show-ahead inputs on the falling edge, commit transfers just before the rising edge.
  initial begin
    clear_model();
    forever begin
      @(negedge clock);
      req0_empty = (rq0.size() == 0);
      req0_dout  = (rq0.size() != 0) ? rq0[0] : 8'd0;
      req1_empty = (rq1.size() == 0);
      req1_dout  = (rq1.size() != 0) ? rq1[0] : 8'd0;
      flt_empty  = (fq.size() == 0);
      flt_dout   = (fq.size() != 0) ? fq[0] : 8'd0;
      cur        = in_busy ? s_cnt : -1;
      flt_full   = fullwin_en && (cur >= 3) && (cur <= 7);
      out0_full  = full0_force;
      out1_full  = full1_force;
      #4;
      if (!reset) begin
        cyc++;
        if (!req0_empty && req_first < 0) req_first = cyc;
        if (in_busy && !prev_busy) begin
          grant_log.push_back(in_grant);
          grant_s0sz.push_back(s0.size());
        end
        prev_busy = in_busy;
        if (in_busy) begin busy_cycles++; s_cnt++; end else s_cnt = 0;
        if (req0_rd_en && flt_full) rd_in_full++;
        if (((req0_rd_en || req1_rd_en) != flt_wr_en) || (req0_rd_en && req1_rd_en)) pass_bad++;
        if (((out0_wr_en || out1_wr_en) != flt_rd_en) || (out0_wr_en && out1_wr_en)) pass_bad++;
        if (flt_rd_en && fq.size() != 0) void'(fq.pop_front());
        if (flt_wr_en) begin
          if (wr_first < 0) wr_first = cyc;
          wr_last = cyc;
          wr_count++;
          fq.push_back(flt_din);
          if (req0_rd_en && rq0.size() != 0) void'(rq0.pop_front());
          else if (req1_rd_en && rq1.size() != 0) void'(rq1.pop_front());
        end
        if (out0_wr_en) begin s0.push_back(out0_din); dest_log.push_back(0); end
        if (out1_wr_en) begin s1.push_back(out1_din); dest_log.push_back(1); end
      end
    end
  end

  // Leaves reset asserted and returns just after a rising edge with the environment emptied.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    full0_force = 1'b0; full1_force = 1'b0; fullwin_en = 1'b0;
    clear_model();
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({req0_rd_en, req1_rd_en, flt_wr_en, flt_rd_en, out0_wr_en, out1_wr_en} !== 6'b0) begin
      bad++;
      $display("FAIL reset_enables: got %b want 000000",
               {req0_rd_en, req1_rd_en, flt_wr_en, flt_rd_en, out0_wr_en, out1_wr_en});
    end
    total++;
    if ({flt_din, out0_din, out1_din} !== 24'd0) begin
      bad++; $display("FAIL reset_data: got %h want 000000", {flt_din, out0_din, out1_din});
    end
    total++;
    if (in_busy !== 1'b0) begin bad++; $display("FAIL reset_in_busy: got %b want 0", in_busy); end
    total++;
    if (in_grant !== 1'b1) begin bad++; $display("FAIL reset_in_grant: got %b want 1", in_grant); end
`ifdef SOBEL_FRAME_ARB_STATS_EN
    total++;
    if ({frames_done0, frames_done1, stall_cycles} !== 48'd0) begin
      bad++; $display("FAIL reset_stats: got %h want 0", {frames_done0, frames_done1, stall_cycles});
    end
`endif
  endtask

  task automatic test_single_frame();
    int e;
    do_reset();
    for (int i = 1; i <= N; i++) rq0.push_back(8'(i));
    release_reset();
    for (int i = 0; i < 200; i++) begin
      if (s0.size() >= N) break;
      @(negedge clock);
    end
    repeat (4) @(negedge clock);
    e = 0;
    for (int i = 0; i < N; i++) if (s0.size() <= i || s0[i] !== 8'(i + 1)) e++;
    total++;
    if (e != 0 || s0.size() != N) begin
      bad++; $display("FAIL single_out0_data: got %0d pixels %0d wrong want 12 pixels 0 wrong", s0.size(), e);
    end
    total++;
    if (wr_first - req_first != 1) begin
      bad++; $display("FAIL single_idle_cycle: got %0d want 1", wr_first - req_first);
    end
    total++;
    if (wr_count != N || wr_last - wr_first != N - 1) begin
      bad++; $display("FAIL single_burst: got count=%0d span=%0d want count=12 span=11", wr_count, wr_last - wr_first);
    end
    total++;
    if (s1.size() != 0) begin bad++; $display("FAIL single_out1_idle: got %0d writes want 0", s1.size()); end
    total++;
    if (in_grant !== 1'b0) begin bad++; $display("FAIL single_grant: got %b want 0", in_grant); end
    total++;
    if (pass_bad != 0) begin bad++; $display("FAIL single_strobes: got %0d bad cycles want 0", pass_bad); end
  endtask

  task automatic test_round_robin();
    int e, d;
    do_reset();
    for (int i = 0; i < 2 * N; i++) begin
      rq0.push_back(8'(100 + i));
      rq1.push_back(8'(200 + i));
    end
    release_reset();
    for (int i = 0; i < 400; i++) begin
      if (s0.size() >= 2 * N && s1.size() >= 2 * N) break;
      @(negedge clock);
    end
    total++;
    if (grant_log.size() != 4 || grant_log[0] !== 1'b0 || grant_log[1] !== 1'b1 ||
        grant_log[2] !== 1'b0 || grant_log[3] !== 1'b1) begin
      bad++; $display("FAIL rr_grants: got %0d grants want 0,1,0,1", grant_log.size());
    end
    e = 0;
    for (int i = 0; i < 2 * N; i++) begin
      if (s0.size() <= i || s0[i] !== 8'(100 + i)) e++;
      if (s1.size() <= i || s1[i] !== 8'(200 + i)) e++;
    end
    total++;
    if (e != 0) begin bad++; $display("FAIL rr_sink_data: got %0d wrong pixels want 0", e); end
    d = 0;
    for (int k = 0; k < 4 * N; k++) if (dest_log.size() <= k || dest_log[k] != (k / N) % 2) d++;
    total++;
    if (d != 0 || dest_log.size() != 4 * N) begin
      bad++; $display("FAIL rr_no_interleave: got %0d misplaced of %0d want 0 of 48", d, dest_log.size());
    end
    total++;
    if (pass_bad != 0) begin bad++; $display("FAIL rr_strobes: got %0d bad cycles want 0", pass_bad); end
  endtask

  task automatic test_flt_backpressure();
    int e;
    do_reset();
    fullwin_en = 1'b1;
    for (int i = 1; i <= N; i++) rq0.push_back(8'(i));
    release_reset();
    for (int i = 0; i < 200; i++) begin
      if (s0.size() >= N) break;
      @(negedge clock);
    end
    repeat (4) @(negedge clock);
    fullwin_en = 1'b0;
    total++;
    if (rd_in_full != 0) begin bad++; $display("FAIL bp_rd_while_full: got %0d want 0", rd_in_full); end
    total++;
    if (wr_count != N) begin bad++; $display("FAIL bp_transfers: got %0d want 12", wr_count); end
    total++;
    if (busy_cycles != N + 5) begin bad++; $display("FAIL bp_stream_cycles: got %0d want 17", busy_cycles); end
    e = 0;
    for (int i = 0; i < N; i++) if (s0.size() <= i || s0[i] !== 8'(i + 1)) e++;
    total++;
    if (e != 0 || s0.size() != N) begin
      bad++; $display("FAIL bp_out0_data: got %0d pixels %0d wrong want 12 pixels 0 wrong", s0.size(), e);
    end
  endtask

  task automatic test_tag_full();
    int e;
    do_reset();
    full0_force = 1'b1;
    for (int i = 1; i <= 2 * N; i++) rq0.push_back(8'(i));
    for (int i = 1; i <= N; i++) rq1.push_back(8'(100 + i));
    release_reset();
    repeat (60) @(negedge clock);
    total++;
    if (grant_log.size() != 2 || in_busy !== 1'b0) begin
      bad++; $display("FAIL tag_full_hold: got grants=%0d busy=%b want grants=2 busy=0", grant_log.size(), in_busy);
    end
    total++;
    if (fq.size() != 2 * N || s0.size() != 0) begin
      bad++; $display("FAIL tag_full_fifo: got filter=%0d out0=%0d want 24 and 0", fq.size(), s0.size());
    end
    full0_force = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (grant_log.size() >= 3) break;
      @(negedge clock);
    end
    total++;
    if (grant_log.size() < 3 || grant_log[2] !== 1'b0 || grant_s0sz[2] != N) begin
      bad++; $display("FAIL tag_third_grant: got grants=%0d want 3rd grant to 0 after 12 drained", grant_log.size());
    end
    for (int i = 0; i < 300; i++) begin
      if (s0.size() >= 2 * N && s1.size() >= N) break;
      @(negedge clock);
    end
    e = 0;
    for (int i = 0; i < 2 * N; i++) if (s0.size() <= i || s0[i] !== 8'(i + 1)) e++;
    for (int i = 0; i < N; i++) if (s1.size() <= i || s1[i] !== 8'(101 + i)) e++;
    total++;
    if (e != 0) begin bad++; $display("FAIL tag_drain_data: got %0d wrong pixels want 0", e); end
  endtask

  task automatic test_mid_frame_reset();
    int e;
    do_reset();
    for (int i = 1; i <= N; i++) rq0.push_back(8'(i));
    release_reset();
    for (int i = 0; i < 100; i++) begin
      if (wr_count >= 5) break;
      @(negedge clock);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if (rq0.size() != N - 5) begin bad++; $display("FAIL rst_pixels_left: got %0d want 7", rq0.size()); end
    fq.delete(); s0.delete(); s1.delete();
    clear_stats();
    for (int i = 13; i <= 17; i++) rq0.push_back(8'(i));
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if ({req0_rd_en, req1_rd_en, flt_wr_en, flt_rd_en, out0_wr_en, out1_wr_en, in_busy, in_grant} !== 8'b00000001) begin
      bad++;
      $display("FAIL rst_after: got %b want 00000001",
               {req0_rd_en, req1_rd_en, flt_wr_en, flt_rd_en, out0_wr_en, out1_wr_en, in_busy, in_grant});
    end
    for (int i = 0; i < 200; i++) begin
      if (s0.size() >= N) break;
      @(negedge clock);
    end
    repeat (4) @(negedge clock);
    total++;
    if (grant_log.size() != 1 || grant_log[0] !== 1'b0) begin
      bad++; $display("FAIL rst_first_grant: got %0d grants want one grant to 0", grant_log.size());
    end
    total++;
    if (wr_count != N || busy_cycles != N) begin
      bad++; $display("FAIL rst_count_from_zero: got wr=%0d busy=%0d want 12 and 12", wr_count, busy_cycles);
    end
    e = 0;
    for (int i = 0; i < N; i++) if (s0.size() <= i || s0[i] !== 8'(i + 6)) e++;
    total++;
    if (e != 0 || s0.size() != N) begin
      bad++; $display("FAIL rst_out0_data: got %0d pixels %0d wrong want 12 pixels 0 wrong", s0.size(), e);
    end
  endtask

`ifdef SOBEL_FRAME_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 2 * N; i++) rq0.push_back(8'(i));
    for (int i = 0; i < N; i++) rq1.push_back(8'(50 + i));
    release_reset();
    for (int i = 0; i < 400; i++) begin
      if (s0.size() >= 2 * N && s1.size() >= N) break;
      @(negedge clock);
    end
    repeat (4) @(negedge clock);
    total++;
    if (frames_done0 !== 16'd2) begin bad++; $display("FAIL stats_done0: got %0d want 2", frames_done0); end
    total++;
    if (frames_done1 !== 16'd1) begin bad++; $display("FAIL stats_done1: got %0d want 1", frames_done1); end
    total++;
    if (stall_cycles !== 16'd0) begin bad++; $display("FAIL stats_stall: got %0d want 0", stall_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_flt_backpressure();
    test_tag_full();
    test_mid_frame_reset();
`ifdef SOBEL_FRAME_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
